// File: rtl/parallel_neuron_pkg.sv
// Shared widths, enums and the saturating truncate used by parallel_neuron.
// Data is signed Q(INTEGER_WIDTH).(FRACTION_WIDTH).
package parallel_neuron_pkg;

    localparam int INTEGER_WIDTH  = 8;
    localparam int FRACTION_WIDTH = 8;
    localparam int DW             = INTEGER_WIDTH + FRACTION_WIDTH;
    localparam int SAT_IN_W       = 64;

    typedef enum logic [1:0] {RELU, IDENTITY, HARD_SIGMOID} activation_type;
    typedef enum logic [1:0] {IDLE, ACCUMULATE, ACTIVATE, OUTPUT} state_t;

    typedef struct packed {
        logic [DW-1:0] value;
        logic          saturated;
    } sat_result_t;

    localparam logic signed [SAT_IN_W-1:0] SAT_MAX = (64'sd1 <<< (DW - 1)) - 64'sd1;
    localparam logic signed [SAT_IN_W-1:0] SAT_MIN = -(64'sd1 <<< (DW - 1));

    // Input carries 2*FRACTION_WIDTH fraction bits; arithmetic shift floors.
    function automatic sat_result_t sat_trunc(input logic signed [SAT_IN_W-1:0] acc);
        logic signed [SAT_IN_W-1:0] floored;
        sat_result_t r;
        floored = acc >>> FRACTION_WIDTH;
        r.saturated = 1'b1;
        if (floored > SAT_MAX)
            r.value = SAT_MAX[DW-1:0];
        else if (floored < SAT_MIN)
            r.value = SAT_MIN[DW-1:0];
        else begin
            r.value     = floored[DW-1:0];
            r.saturated = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/parallel_neuron_if.sv
// Weight/bias load, input and output handshake bundle for parallel_neuron.
interface parallel_neuron_if #(
    parameter int NUM_INPUTS = 16
) ();
    localparam int DW = parallel_neuron_pkg::DW;
    localparam int AW = $clog2(NUM_INPUTS);

    logic                           weight_write_enable;
    logic [AW-1:0]                  weight_address;
    logic [DW-1:0]                  weight_data;
    logic                           bias_write_enable;
    logic [DW-1:0]                  bias_data;
    logic                           inputs_valid;
    logic [NUM_INPUTS-1:0][DW-1:0]  inputs;
    logic                           inputs_ready;
    logic [DW-1:0]                  out;
    logic                           out_valid;
    logic                           out_ready;

    modport master (
        output weight_write_enable, weight_address, weight_data,
        output bias_write_enable, bias_data,
        output inputs_valid, inputs, out_ready,
        input  inputs_ready, out, out_valid
    );

    modport slave (
        input  weight_write_enable, weight_address, weight_data,
        input  bias_write_enable, bias_data,
        input  inputs_valid, inputs, out_ready,
        output inputs_ready, out, out_valid
    );

endinterface

// File: rtl/neuron_activation.sv
// Combinational floor/saturate of the accumulator followed by the selected
// activation function; also reports whether the saturation clipped.
module neuron_activation
    import parallel_neuron_pkg::*;
#(
    parameter int             ACC_W      = 35,
    parameter activation_type ACTIVATION = RELU
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [DW-1:0]    result,
    output logic                    saturated
);

    localparam logic signed [DW-1:0] HALF = DW'(1 << (FRACTION_WIDTH - 1));
    localparam logic signed [DW-1:0] ONE  = DW'(1 << FRACTION_WIDTH);

    sat_result_t             st;
    logic signed [DW-1:0]    x;
    logic signed [DW-1:0]    hs;

    always_comb begin
        st        = sat_trunc({{(SAT_IN_W - ACC_W){acc[ACC_W-1]}}, acc});
        x         = st.value;
        // x/4 + 0.5 cannot overflow DW: |x/4| <= 2^(DW-3).
        hs        = (x >>> 2) + HALF;
        saturated = st.saturated;
        case (ACTIVATION)
            RELU:         result = x[DW-1] ? '0 : st.value;
            IDENTITY:     result = st.value;
            HARD_SIGMOID: begin
                if (hs < 0)        result = '0;
                else if (hs > ONE) result = ONE;
                else               result = hs;
            end
            default:      result = st.value;
        endcase
    end

endmodule

// File: rtl/parallel_neuron.sv
// Multi-lane MAC neuron: NUM_LANES products per cycle into a wide accumulator,
// then activation. Optional 16-bit saturation counter: NEURON_SATURATION_COUNT_EN.
module parallel_neuron
    import parallel_neuron_pkg::*;
#(
    parameter int             NUM_INPUTS = 16,
    parameter int             NUM_LANES  = 4,
    parameter activation_type ACTIVATION = RELU
) (
    input  logic clock,
    input  logic reset_n,
    parallel_neuron_if.slave bus
`ifdef NEURON_SATURATION_COUNT_EN
    ,
    output logic [15:0] saturation_count
`endif
);

    localparam int STEPS  = NUM_INPUTS / NUM_LANES;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int IDX_W  = $clog2(NUM_INPUTS);
    localparam int ACC_W  = $clog2(NUM_INPUTS) + 2 * INTEGER_WIDTH + 1 + 2 * FRACTION_WIDTH;
    localparam int PROD_W = 2 * DW;

    state_t                          state_q, state_d;
    logic [STEP_W-1:0]               step_q;
    logic [NUM_INPUTS-1:0][DW-1:0]   in_q;
    logic [NUM_INPUTS-1:0][DW-1:0]   w_q;
    logic [DW-1:0]                   bias_q;
    logic signed [ACC_W-1:0]         acc_q;
    logic signed [ACC_W-1:0]         psum_q;
    logic                            prod_vld_q;
    logic [DW-1:0]                   out_q;
    logic                            out_valid_q;

    logic                            inputs_ready;
    logic                            accept;
    logic [NUM_LANES-1:0][PROD_W-1:0] lane_prod;
    logic signed [ACC_W-1:0]         lane_sum;
    logic signed [ACC_W-1:0]         bias_aligned;
    logic [DW-1:0]                   act_out;
    logic                            act_sat;

    assign inputs_ready     = (state_q == IDLE) && !bus.weight_write_enable && !bus.bias_write_enable;
    assign accept           = bus.inputs_valid && inputs_ready;
    assign bus.inputs_ready = inputs_ready;
    assign bus.out          = out_q;
    assign bus.out_valid    = out_valid_q;
    assign bias_aligned     = {{(ACC_W - DW - FRACTION_WIDTH){bias_q[DW-1]}}, bias_q,
                               {FRACTION_WIDTH{1'b0}}};

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [IDX_W-1:0] idx;
        assign idx          = IDX_W'(int'(step_q) * NUM_LANES + k);
        assign lane_prod[k] = $signed(in_q[idx]) * $signed(w_q[idx]);
    end

    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < NUM_LANES; k++)
            lane_sum = lane_sum + ACC_W'($signed(lane_prod[k]));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (accept) state_d = ACCUMULATE;
            ACCUMULATE: if (step_q == STEP_W'(STEPS - 1)) state_d = ACTIVATE;
            ACTIVATE:   state_d = OUTPUT;
            OUTPUT:     if (out_valid_q && bus.out_ready) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Products are registered once; ACTIVATE drains the last partial sum and
    // the first OUTPUT cycle registers the activated result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            step_q      <= '0;
            in_q        <= '0;
            w_q         <= '0;
            bias_q      <= '0;
            acc_q       <= '0;
            psum_q      <= '0;
            prod_vld_q  <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (state_q == IDLE && bus.weight_write_enable)
                w_q[bus.weight_address] <= bus.weight_data;
            if (state_q == IDLE && bus.bias_write_enable)
                bias_q <= bus.bias_data;
            prod_vld_q <= (state_q == ACCUMULATE);
            if (state_q == ACCUMULATE) begin
                psum_q <= lane_sum;
                step_q <= step_q + 1'b1;
            end
            if (accept) begin
                in_q   <= bus.inputs;
                acc_q  <= bias_aligned;
                step_q <= '0;
            end else if (prod_vld_q) begin
                acc_q  <= acc_q + psum_q;
            end
            if (state_q == OUTPUT && !out_valid_q) begin
                out_q       <= act_out;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    neuron_activation #(
        .ACC_W      (ACC_W),
        .ACTIVATION (ACTIVATION)
    ) u_act (
        .acc       (acc_q),
        .result    (act_out),
        .saturated (act_sat)
    );

`ifdef NEURON_SATURATION_COUNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            saturation_count <= '0;
        else if (state_q == OUTPUT && !out_valid_q && act_sat && saturation_count != 16'hFFFF)
            saturation_count <= saturation_count + 16'd1;
    end
`else
    logic unused_sat;
    assign unused_sat = act_sat;
`endif

endmodule

// File: tb/tb_parallel_neuron.sv
// Directed bench: RELU, IDENTITY and HARD_SIGMOID neurons run in lockstep
// (NUM_INPUTS=4, NUM_LANES=2, Q8.8) on shared stimulus.
module tb_parallel_neuron;
    import parallel_neuron_pkg::*;

    localparam int NI = 4;
    localparam int NL = 2;

    logic clock;
    logic reset_n;
    logic we, bw, inv, ordy;
    logic [1:0] wa;
    logic [15:0] wd, bd;
    logic [NI-1:0][15:0] vin;

    logic [15:0] out_w [3];
    logic        ov    [3];
    logic        ir    [3];
`ifdef NEURON_SATURATION_COUNT_EN
    logic [15:0] satc  [3];
`endif

    int n_chk = 0;
    int n_err = 0;

    parallel_neuron_if #(.NUM_INPUTS(NI)) bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].weight_write_enable = we;
        assign bus[g].weight_address      = wa;
        assign bus[g].weight_data         = wd;
        assign bus[g].bias_write_enable   = bw;
        assign bus[g].bias_data           = bd;
        assign bus[g].inputs_valid        = inv;
        assign bus[g].inputs              = vin;
        assign bus[g].out_ready           = ordy;
        assign out_w[g] = bus[g].out;
        assign ov[g]    = bus[g].out_valid;
        assign ir[g]    = bus[g].inputs_ready;

        parallel_neuron #(
            .NUM_INPUTS (NI),
            .NUM_LANES  (NL),
            .ACTIVATION (activation_type'(g))
        ) u_dut (
            .clock   (clock),
            .reset_n (reset_n),
            .bus     (bus[g])
`ifdef NEURON_SATURATION_COUNT_EN
            ,
            .saturation_count (satc[g])
`endif
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wr_weight(input logic [1:0] a, input logic [15:0] d);
        @(negedge clock);
        we = 1'b1; wa = a; wd = d;
        @(negedge clock);
        we = 1'b0;
    endtask

    task automatic wr_bias(input logic [15:0] d);
        @(negedge clock);
        bw = 1'b1; bd = d;
        @(negedge clock);
        bw = 1'b0;
    endtask

    task automatic load_all(input logic [15:0] w, input logic [15:0] b);
        for (int i = 0; i < NI; i++) wr_weight(2'(i), w);
        wr_bias(b);
    endtask

    // Returns just after the accept edge with inputs scrambled.
    task automatic start_eval(input string tag, input logic [NI-1:0][15:0] v);
        int n;
        @(negedge clock);
        inv = 1'b1; vin = v;
        n = 0;
        while (!ir[0] && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "/ready"}, 32'(ir[0]), 32'd1);
        @(posedge clock);
        #1;
        inv = 1'b0;
        vin = {NI{16'hDEAD}};
    endtask

    task automatic wait_out(input string tag);
        int lat;
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
        end while (!ov[0] && lat < 20);
        chk({tag, "/latency"}, 32'(lat), 32'd4);
    endtask

    task automatic check_out(input string tag, input logic [15:0] er, input logic [15:0] ei,
                             input logic [15:0] eh);
        chk({tag, "/relu"},  32'(out_w[0]), 32'(er));
        chk({tag, "/ident"}, 32'(out_w[1]), 32'(ei));
        chk({tag, "/hsig"},  32'(out_w[2]), 32'(eh));
    endtask

    task automatic handshake(input string tag);
        @(negedge clock);
        ordy = 1'b1;
        @(posedge clock);
        #1;
        ordy = 1'b0;
        chk({tag, "/valid_drop"}, 32'(ov[0]), 32'd0);
        chk({tag, "/ready_back"}, 32'(ir[0]), 32'd1);
    endtask

    task automatic run(input string tag, input logic [NI-1:0][15:0] v, input logic [15:0] er,
                       input logic [15:0] ei, input logic [15:0] eh);
        start_eval(tag, v);
        wait_out(tag);
        check_out(tag, er, ei, eh);
        handshake(tag);
    endtask

    logic [NI-1:0][15:0] v_one, v_neg, v_big, v_lane, v_floor;
    logic seen;

    initial begin
        v_one   = {NI{16'h0100}};
        v_neg   = {NI{16'hFF00}};
        v_big   = {NI{16'h6400}};
        v_lane  = {16'h0200, 16'h0000, 16'h0000, 16'h0100};
        v_floor = {16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
        we = 0; bw = 0; inv = 0; ordy = 0; wa = '0; wd = '0; bd = '0; vin = '0;

        reset_n = 1'b0;
        #12;
        chk("reset/valid", 32'(ov[0]), 32'd0);
        chk("reset/out",   32'(out_w[1]), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("reset/ready", 32'(ir[0]), 32'd1);
`ifdef NEURON_SATURATION_COUNT_EN
        chk("reset/satcnt", 32'(satc[0]), 32'd0);
`endif

        load_all(16'h0300, 16'h0300);
        run("ones",  v_one, 16'h0F00, 16'h0F00, 16'h0100);
        run("neg",   v_neg, 16'h0000, 16'hF700, 16'h0000);
`ifdef NEURON_SATURATION_COUNT_EN
        chk("nosat/satcnt", 32'(satc[0]), 32'd0);
`endif
        run("big",   v_big, 16'h7FFF, 16'h7FFF, 16'h0100);
`ifdef NEURON_SATURATION_COUNT_EN
        chk("sat/satcnt_relu",  32'(satc[0]), 32'd1);
        chk("sat/satcnt_ident", 32'(satc[1]), 32'd1);
`endif

        // Output back-pressure with a competing request held on the input side.
        start_eval("hold", v_one);
        wait_out("hold");
        check_out("hold", 16'h0F00, 16'h0F00, 16'h0100);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            inv = 1'b1; vin = v_neg;
            chk("hold/valid", 32'(ov[0]), 32'd1);
            chk("hold/out",   32'(out_w[0]), 32'h0F00);
            chk("hold/ready", 32'(ir[0]), 32'd0);
        end
        handshake("hold");
        @(posedge clock);
        #1;
        inv = 1'b0; vin = {NI{16'hDEAD}};
        wait_out("second");
        check_out("second", 16'h0000, 16'hF700, 16'h0000);
        handshake("second");

        // Reset in the middle of accumulation.
        start_eval("rst", v_one);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst/valid", 32'(ov[1]), 32'd0);
        chk("rst/out",   32'(out_w[1]), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clock);
            #1;
            if (ov[0] || ov[1] || ov[2]) seen = 1'b1;
        end
        chk("rst/no_valid", 32'(seen), 32'd0);
`ifdef NEURON_SATURATION_COUNT_EN
        chk("rst/satcnt", 32'(satc[0]), 32'd0);
`endif
        run("zero_w", v_one, 16'h0000, 16'h0000, 16'h0080);

        wr_bias(16'h0400);
        run("bias4", v_one, 16'h0400, 16'h0400, 16'h0100);

        // -1/256 * 0.5 floors to -1/256.
        wr_weight(2'd0, 16'h0080);
        wr_bias(16'h0000);
        run("floor", v_floor, 16'h0000, 16'hFFFF, 16'h007F);

        // Distinct weights expose lane/step indexing; writes mid-run are dropped.
        wr_weight(2'd0, 16'h0100);
        wr_weight(2'd1, 16'h0200);
        wr_weight(2'd2, 16'h0300);
        wr_weight(2'd3, 16'h0400);
        start_eval("lane", v_lane);
        we = 1'b1; wa = 2'd0; wd = 16'h7F00;
        bw = 1'b1; bd = 16'h7F00;
        wait_out("lane");
        we = 1'b0; bw = 1'b0;
        check_out("lane", 16'h0900, 16'h0900, 16'h0100);
        handshake("lane");
        run("lane2", v_lane, 16'h0900, 16'h0900, 16'h0100);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/parallel_neuron.md
PARALLEL_NEURON -- requirements
Module: parallel_neuron

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 16, number of inputs per evaluation.
REQ-002 SHALL have parameter NUM_LANES, default 4, multipliers per cycle; NUM_INPUTS divisible by NUM_LANES.
REQ-003 SHALL have parameter ACTIVATION (activation_type), default RELU; legal values RELU, IDENTITY, HARD_SIGMOID.
REQ-004 SHALL use package widths INTEGER_WIDTH/FRACTION_WIDTH; data is signed Q(INTEGER_WIDTH).(FRACTION_WIDTH), width DW.
REQ-005 Ports: clock  in  1  single clock; all logic on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 weight_write_enable  in  1; weight_address  in  $clog2(NUM_INPUTS); weight_data  in  DW  weight load.
REQ-008 bias_write_enable  in  1; bias_data  in  DW  bias load.
REQ-009 inputs_valid  in  1; inputs  in  DW x NUM_INPUTS; inputs_ready  out  1  input handshake.
REQ-010 out  out  DW; out_valid  out  1; out_ready  in  1  output handshake.

Function
REQ-011 States IDLE, ACCUMULATE, ACTIVATE, OUTPUT; IDLE->ACCUMULATE on input accept; ACCUMULATE->ACTIVATE after NUM_INPUTS/NUM_LANES cycles; ACTIVATE->OUTPUT after 1 cycle; OUTPUT->IDLE on out_valid && out_ready.
REQ-012 inputs_ready = (state==IDLE) && !weight_write_enable && !bias_write_enable; writes take priority over accept.
REQ-013 Accept (inputs_valid && inputs_ready) SHALL capture all inputs into an internal register; upstream may change inputs afterwards.
REQ-014 Weight/bias writes SHALL take effect only in IDLE; writes in other states SHALL be ignored.
REQ-015 Accumulator SHALL load bias (aligned to 2*FRACTION_WIDTH fraction bits) on accept, then add NUM_LANES products per ACCUMULATE cycle, lane k of step s using index s*NUM_LANES+k.
REQ-016 Accumulator width: $clog2(NUM_INPUTS)+2*INTEGER_WIDTH+1 integer bits, 2*FRACTION_WIDTH fraction bits; no internal overflow.
REQ-017 Result SHALL truncate (floor) the low FRACTION_WIDTH fraction bits, then saturate to [-2^(DW-1), 2^(DW-1)-1].
REQ-018 RELU: negative -> 0, else saturated result; IDENTITY: saturated result; HARD_SIGMOID: clamp(x/4 + 0.5, 0, 1.0) (requires INTEGER_WIDTH>=2).
REQ-019 out_valid SHALL assert exactly NUM_INPUTS/NUM_LANES + 2 cycles after the accept edge.
REQ-020 out and out_valid SHALL hold stable while out_ready is low; no new accept until OUTPUT exits.
REQ-021 out SHALL retain its last value after the handshake until the next ACTIVATE.

Reset
REQ-022 reset_n low SHALL immediately force: state IDLE, out 0, out_valid 0, accumulator 0, weights 0, bias 0, input register 0.
REQ-023 Reset mid-ACCUMULATE or mid-OUTPUT SHALL abandon the evaluation; no out_valid after release until a new accept.
REQ-024 inputs_ready SHALL be 1 in the first cycle after reset_n release (absent writes).

Configuration
REQ-025 Macro NEURON_SATURATION_COUNT_EN defined: output port saturation_count (16 bits) SHALL increment once per evaluation whose result saturated in REQ-017, sticking at 0xFFFF, reset to 0.
REQ-026 Macro undefined: port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-027 activation_type enum, INTEGER_WIDTH, FRACTION_WIDTH, and a saturating-truncate function SHALL live in the shared package.
REQ-028 One sub-module neuron_activation (combinational: accumulator in, ACTIVATION parameter, DW out plus saturated flag) SHALL be instantiated once.

Verification (NUM_INPUTS=4, NUM_LANES=2, Q8.8, 1.0=0x0100)
REQ-029 Weights all 0x0300, bias 0x0300, inputs all 0x0100, RELU -> out=0x0F00, out_valid 4 cycles after accept.
REQ-030 Same weights/bias, inputs all 0xFF00 (-1.0), RELU -> out=0x0000; IDENTITY -> out=0xF700 (-9.0).
REQ-031 Inputs all 0x6400 (100.0), weights 0x0300, RELU -> out=0x7FFF; saturation_count 0->1 when macro defined.
REQ-032 out_ready low 5 cycles after out_valid -> out/out_valid stable, inputs_ready 0, second inputs_valid not accepted until handshake.
REQ-033 reset_n low during ACCUMULATE -> out_valid 0, out 0, weights read back as zero (re-run REQ-029 stimulus without reloading -> out=0x0000).
REQ-034 HARD_SIGMOID, weights 0, bias 0 -> out=0x0080; bias 0x0400 -> out=0x0100.
